// File: rtl/stream_arbiter_wrr.sv
`default_nettype none
// ============================================================================
// Module   : stream_arbiter_wrr
// Purpose  : Weighted round-robin arbiter sharing one valid/ready output
//            stream among N_INP input streams. Each input may send up to
//            weight_i[i] consecutive beats (0 counts as 1) before the grant
//            rotates. Once a beat is offered and stalled, the grant stays
//            locked so the output payload is stable until the handshake.
//            The payload path is purely combinational (zero latency).
// Ports    : clk_i        - clock, rising edge
//            rst_i        - asynchronous active-high reset
//            clr_i        - synchronous clear of arbitration state
//            flush_i      - abort current grant/burst (outputs muted)
//            weight_i     - per-input burst length in beats
//            inp_data_i   - per-input payloads
//            inp_valid_i  - per-input valids
//            inp_ready_o  - per-input readies (one-hot or zero)
//            oup_data_o   - selected payload
//            oup_valid_o  - output valid
//            oup_ready_i  - output ready
//            oup_idx_o    - index of the selected input
// Revision : 1.0 - initial release
// ============================================================================
module stream_arbiter_wrr #(
  parameter type DATA_T  = logic,
  parameter int  N_INP   = 4,
  parameter int  W_WIDTH = 4,
  parameter int  IDX_W   = $clog2(N_INP)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clr_i,
  input  logic                            flush_i,
  input  logic [N_INP-1:0][W_WIDTH-1:0]   weight_i,
  input  DATA_T [N_INP-1:0]               inp_data_i,
  input  logic [N_INP-1:0]                inp_valid_i,
  output logic [N_INP-1:0]                inp_ready_o,
  output DATA_T                           oup_data_o,
  output logic                            oup_valid_o,
  input  logic                            oup_ready_i,
  output logic [IDX_W-1:0]                oup_idx_o
);

  // Arbitration state
  logic [IDX_W-1:0]   r_cur;    // last / currently granted input
  logic [W_WIDTH-1:0] r_cred;   // beats left in current burst, 0 = none
  logic               r_lock;   // a stalled beat is pending on r_cur

  // Combinational selection
  logic [IDX_W-1:0]   w_sel;
  logic [IDX_W-1:0]   w_search;
  logic [IDX_W-1:0]   w_probe_idx;
  logic               w_found;
  logic               w_new_burst;
  int                 w_probe;
  logic [W_WIDTH-1:0] w_weight_sel;
  logic [W_WIDTH-1:0] w_eff;
  logic [W_WIDTH-1:0] w_cred_base;
  logic               w_valid;

  // Round-robin search: first valid input after r_cur, wrapping, r_cur last.
  always_comb begin
    w_found     = 1'b0;
    w_search    = r_cur;
    w_probe     = 0;
    w_probe_idx = '0;
    for (int k = 1; k <= N_INP; k++) begin
      w_probe = int'(r_cur) + k;
      if (w_probe >= N_INP) begin
        w_probe = w_probe - N_INP;
      end
      w_probe_idx = IDX_W'(w_probe);
      if (!w_found && inp_valid_i[w_probe_idx]) begin
        w_found  = 1'b1;
        w_search = w_probe_idx;
      end
    end
  end

  // Grant choice: locked beat first, then an ongoing burst, then a new burst.
  // Starting a new burst discards any credit the previous owner had left.
  always_comb begin
    w_sel       = r_cur;
    w_new_burst = 1'b0;
    if (r_lock) begin
      w_sel = r_cur;
    end else if ((r_cred != '0) && inp_valid_i[r_cur]) begin
      w_sel = r_cur;
    end else if (w_found) begin
      w_sel       = w_search;
      w_new_burst = 1'b1;
    end
  end

  // A zero weight still grants one beat per burst.
  assign w_weight_sel = weight_i[w_sel];
  assign w_eff        = (w_weight_sel == '0) ? W_WIDTH'(1) : w_weight_sel;
  assign w_cred_base  = w_new_burst ? w_eff : r_cred;

  // rst_i gates the output combinationally so valid drops immediately,
  // independent of the clock.
  assign w_valid = (r_lock | (|inp_valid_i)) & ~rst_i & ~clr_i & ~flush_i;

  assign oup_valid_o = w_valid;
  assign oup_data_o  = inp_data_i[w_sel];
  assign oup_idx_o   = w_sel;

  always_comb begin
    inp_ready_o = '0;
    if (w_valid && oup_ready_i) begin
      inp_ready_o[w_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cur  <= IDX_W'(N_INP - 1);
      r_cred <= '0;
      r_lock <= 1'b0;
    end else if (clr_i) begin
      r_cur  <= IDX_W'(N_INP - 1);
      r_cred <= '0;
      r_lock <= 1'b0;
    end else if (flush_i) begin
      // Next arbitration searches fresh from r_cur + 1.
      r_cred <= '0;
      r_lock <= 1'b0;
    end else if (w_valid) begin
      r_cur <= w_sel;
      if (oup_ready_i) begin
        // w_cred_base >= 1 here, so the decrement never wraps.
        r_cred <= w_cred_base - W_WIDTH'(1);
        r_lock <= 1'b0;
      end else begin
        r_cred <= w_cred_base;
        r_lock <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_arbiter_wrr.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_arbiter_wrr
// Purpose  : Self-checking bench for stream_arbiter_wrr (N_INP=4, 8-bit data).
//            A behavioural model tracks owner / beats left / pending beat and
//            is compared with the DUT every cycle; directed scenarios also
//            check hand-computed grant sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_arbiter_wrr;

  localparam int N = 4;

  logic              clk    = 1'b0;
  logic              rst    = 1'b1;
  logic              clr    = 1'b0;
  logic              flush  = 1'b0;
  logic              oready = 1'b0;
  logic [N-1:0][3:0] weight;
  logic [N-1:0][7:0] data;
  logic [N-1:0]      valid  = '0;
  logic [N-1:0]      iready;
  logic [7:0]        odata;
  logic              ovalid;
  logic [1:0]        oidx;

  int errors = 0;
  int checks = 0;
  int hs_log[$];

  stream_arbiter_wrr #(
    .DATA_T  (logic [7:0]),
    .N_INP   (N),
    .W_WIDTH (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clr_i       (clr),
    .flush_i     (flush),
    .weight_i    (weight),
    .inp_data_i  (data),
    .inp_valid_i (valid),
    .inp_ready_o (iready),
    .oup_data_o  (odata),
    .oup_valid_o (ovalid),
    .oup_ready_i (oready),
    .oup_idx_o   (oidx)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_owner = N - 1;   // input that owns / last owned the grant
  int m_left  = 0;       // beats remaining in the owner's burst
  bit m_hold  = 1'b0;    // a beat was offered but not yet accepted

  function automatic bit m_continues();
    return (m_left > 0) && valid[m_owner];
  endfunction

  function automatic int m_sel();
    if (m_hold || m_continues()) return m_owner;
    for (int k = 1; k <= N; k++) begin
      if (valid[(m_owner + k) % N]) return (m_owner + k) % N;
    end
    return m_owner;
  endfunction

  function automatic bit m_valid();
    return !rst && !clr && !flush && (m_hold || (valid != '0));
  endfunction

  always @(posedge clk or posedge rst) begin
    int s;
    int w;
    bit fresh;
    if (rst || clr) begin
      m_owner = N - 1;
      m_left  = 0;
      m_hold  = 1'b0;
    end else if (flush) begin
      m_left = 0;
      m_hold = 1'b0;
    end else if (m_valid()) begin
      s     = m_sel();
      w     = (weight[s] == 4'd0) ? 1 : int'(weight[s]);
      fresh = !m_hold && !m_continues();
      if (fresh) m_left = w;
      m_owner = s;
      if (oready) begin
        m_left = m_left - 1;
        m_hold = 1'b0;
      end else begin
        m_hold = 1'b1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit ev;
    int es;
    ev = m_valid();
    es = m_sel();
    chk("valid", {63'd0, ovalid}, {63'd0, ev});
    chk("inp_ready", {60'd0, iready}, (ev && oready) ? (64'd1 << es) : 64'd0);
    if (ev) begin
      chk("idx", {62'd0, oidx}, 64'(es));
      chk("data", {56'd0, odata}, {56'd0, data[es]});
    end
    if (ovalid === 1'b1 && oready) hs_log.push_back(int'(oidx));
  end

  task automatic check_log(input string name, input int e[$]);
    chk($sformatf("%s_len", name), 64'(hs_log.size()), 64'(e.size()));
    for (int i = 0; i < e.size(); i++) begin
      if (i < hs_log.size()) chk($sformatf("%s[%0d]", name, i), 64'(hs_log[i]), 64'(e[i]));
    end
    hs_log.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_state();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    hs_log.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e[$];
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
    data   = {8'h13, 8'h12, 8'h11, 8'h10};
    repeat (2) @(posedge clk);
    #1;
    // Reset values
    chk("rst_valid", {63'd0, ovalid}, 64'd0);
    chk("rst_ready", {60'd0, iready}, 64'd0);
    chk("rst_idx",   {62'd0, oidx},   64'd3);
    chk("rst_data",  {56'd0, odata},  64'h13);
    rst = 1'b0;
    hs_log.delete();

    // Plain round robin, all weights 1
    valid = 4'b1111; oready = 1'b1;
    repeat (6) tick();
    valid = 4'b0000;
    e = {0, 1, 2, 3, 0, 1};
    check_log("rr", e);
    clear_state();

    // w0=3, w1=1
    weight = {4'd1, 4'd1, 4'd1, 4'd3};
    valid  = 4'b0011;
    repeat (8) tick();
    valid = 4'b0000;
    e = {0, 0, 0, 1, 0, 0, 0, 1};
    check_log("wrr", e);
    clear_state();

    // Stall on input 0, input 1 joins while locked
    weight  = {4'd1, 4'd1, 4'd1, 4'd1};
    data[0] = 8'hA5;
    valid   = 4'b0001; oready = 1'b0;
    tick();
    valid = 4'b0011;
    tick();
    tick();
    #1;
    chk("lock_valid", {63'd0, ovalid}, 64'd1);
    chk("lock_idx",   {62'd0, oidx},   64'd0);
    chk("lock_data",  {56'd0, odata},  64'hA5);
    chk("lock_ready", {60'd0, iready}, 64'd0);
    oready = 1'b1;
    tick();
    tick();
    valid   = 4'b0000;
    data[0] = 8'h10;
    e = {0, 1};
    check_log("lock", e);
    clear_state();

    // Credit forfeit: input 0 drops valid mid-burst
    weight = {4'd1, 4'd2, 4'd1, 4'd4};
    valid  = 4'b0101;
    tick(); tick();
    valid = 4'b0100;
    tick();
    valid = 4'b0101;
    tick(); tick();
    valid = 4'b0000;
    e = {0, 0, 2, 2, 0};
    check_log("forfeit", e);
    clear_state();

    // Flush while locked on input 1
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
    valid  = 4'b0010; oready = 1'b0;
    tick();
    flush = 1'b1;
    valid = 4'b0110;
    #1;
    chk("flush_valid", {63'd0, ovalid}, 64'd0);
    chk("flush_ready", {60'd0, iready}, 64'd0);
    tick();
    flush  = 1'b0;
    oready = 1'b1;
    #1;
    chk("post_flush_idx", {62'd0, oidx}, 64'd2);
    tick();
    valid = 4'b0000;
    e = {2};
    check_log("flush", e);
    clear_state();

    // Zero weight behaves as 1
    weight = {4'd0, 4'd1, 4'd1, 4'd1};
    valid  = 4'b1000;
    repeat (3) tick();
    valid = 4'b1001;
    tick();
    valid = 4'b0000;
    e = {3, 3, 3, 0};
    check_log("w_zero", e);

    // Asynchronous reset while locked
    valid  = 4'b0010; oready = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {63'd0, ovalid}, 64'd0);
    chk("arst_ready", {60'd0, iready}, 64'd0);
    valid  = 4'b0110;
    oready = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("arst_first_idx", {62'd0, oidx}, 64'd1);
    tick();
    valid = 4'b0000;
    e = {1};
    check_log("arst", e);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
